// File: rtl/sfp_frame_rx_if.sv
// Serial-side and drive-word signals of the SFP frame receiver.
// master = line/stimulus side, slave = receiver.
interface sfp_frame_rx_if;
  logic       i_rxd;
  logic       i_sfp_loss_sig;
  logic [7:0] o_data;
  logic       o_data_vld;
  logic       o_par_err;
  logic       o_frm_err;
  logic       o_link_ok;
  logic [7:0] o_out;

  modport master (
    output i_rxd, i_sfp_loss_sig,
    input  o_data, o_data_vld, o_par_err, o_frm_err, o_link_ok, o_out
  );

  modport slave (
    input  i_rxd, i_sfp_loss_sig,
    output o_data, o_data_vld, o_par_err, o_frm_err, o_link_ok, o_out
  );
endinterface

// File: rtl/sfp_frame_rx.sv
// SFP link receiver: recovers 11-bit gate frames from the oversampled line and
// qualifies the link. Optional macro SFP_RX_MAJORITY_EN: 2-of-3 bit voting.
module sfp_frame_rx #(
  parameter int unsigned OVS      = 4,
  parameter int unsigned TIMEOUT  = 600,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic            i_clk,
  input  logic            i_res_n,
  sfp_frame_rx_if.slave   bus
);

  localparam int unsigned TW  = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int unsigned TOW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW  = $clog2(LOCK_CNT + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
  } state_e;

  logic rxd_s1_q, rxd_s2_q, rxd_h1_q;
  logic los_s1_q, los_s2_q;
`ifdef SFP_RX_MAJORITY_EN
  logic rxd_h2_q;
`endif

  state_e           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       sh_q, sh_d;
  logic             par_bad_q, par_bad_d;
  logic [7:0]       data_q, data_d;
  logic             vld_q, vld_d;
  logic             par_err_q, par_err_d;
  logic             frm_err_q, frm_err_d;
  logic             link_q, link_d;
  logic [7:0]       out_q, out_d;
  logic [TOW-1:0]   to_q, to_d;
  logic [GW-1:0]    good_q, good_d;
  logic             bit_c, tick_c, good_evt_c, err_evt_c;

  // Line and LOS synchronisers; rxd history feeds edge detect and bit decision.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
      rxd_h1_q <= 1'b1;
      los_s1_q <= 1'b1;
      los_s2_q <= 1'b1;
`ifdef SFP_RX_MAJORITY_EN
      rxd_h2_q <= 1'b1;
`endif
    end else begin
      rxd_s1_q <= bus.i_rxd;
      rxd_s2_q <= rxd_s1_q;
      rxd_h1_q <= rxd_s2_q;
      los_s1_q <= bus.i_sfp_loss_sig;
      los_s2_q <= los_s1_q;
`ifdef SFP_RX_MAJORITY_EN
      rxd_h2_q <= rxd_h1_q;
`endif
    end
  end

  // Decision is made one clock after the nominal sample so both modes share latency.
`ifdef SFP_RX_MAJORITY_EN
  assign bit_c = (rxd_s2_q & rxd_h1_q) | (rxd_s2_q & rxd_h2_q) | (rxd_h1_q & rxd_h2_q);
`else
  assign bit_c = rxd_h1_q;
`endif

  assign tick_c = (tmr_q == '0);

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    par_bad_d  = par_bad_q;
    data_d     = data_q;
    vld_d      = 1'b0;
    par_err_d  = 1'b0;
    frm_err_d  = 1'b0;
    link_d     = link_q;
    to_d       = to_q;
    good_d     = good_q;
    good_evt_c = 1'b0;
    err_evt_c  = 1'b0;
    out_d      = link_q ? data_q : 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (rxd_h1_q && !rxd_s2_q) begin
          state_d = ST_START;
          tmr_d   = TW'(OVS / 2);
        end
      end
      ST_START: begin
        if (!tick_c) begin
          tmr_d = tmr_q - TW'(1);
        end else if (bit_c) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_DATA;
          tmr_d     = TW'(OVS - 1);
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (!tick_c) begin
          tmr_d = tmr_q - TW'(1);
        end else begin
          sh_d      = {bit_c, sh_q[7:1]};
          tmr_d     = TW'(OVS - 1);
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (!tick_c) begin
          tmr_d = tmr_q - TW'(1);
        end else begin
          par_bad_d = bit_c ^ (^sh_q);
          tmr_d     = TW'(OVS - 1);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!tick_c) begin
          tmr_d = tmr_q - TW'(1);
        end else if (!bit_c) begin
          frm_err_d = 1'b1;
          err_evt_c = 1'b1;
          state_d   = ST_BREAK;
        end else if (par_bad_q) begin
          par_err_d = 1'b1;
          err_evt_c = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          data_d     = sh_q;
          vld_d      = 1'b1;
          good_evt_c = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_BREAK: begin
        if (rxd_s2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Loss of light wins over everything, including a frame completing now.
    if (los_s2_q) begin
      state_d   = ST_IDLE;
      data_d    = data_q;
      vld_d     = 1'b0;
      par_err_d = 1'b0;
      frm_err_d = 1'b0;
      to_d      = TOW'(TIMEOUT);
      good_d    = '0;
      link_d    = 1'b0;
    end else begin
      if (good_evt_c)                      to_d = '0;
      else if (to_q != TOW'(TIMEOUT))      to_d = to_q + TOW'(1);
      if (err_evt_c)                       good_d = '0;
      else if (good_evt_c && good_q != GW'(LOCK_CNT)) good_d = good_q + GW'(1);
      if (good_d == GW'(LOCK_CNT))         link_d = 1'b1;
      if (to_d == TOW'(TIMEOUT)) begin
        good_d = '0;
        link_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      bit_cnt_q <= 3'd0;
      sh_q      <= 8'h00;
      par_bad_q <= 1'b0;
      data_q    <= 8'h00;
      vld_q     <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      link_q    <= 1'b0;
      out_q     <= 8'h00;
      to_q      <= TOW'(TIMEOUT);
      good_q    <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      par_bad_q <= par_bad_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      link_q    <= link_d;
      out_q     <= out_d;
      to_q      <= to_d;
      good_q    <= good_d;
    end
  end

  assign bus.o_data     = data_q;
  assign bus.o_data_vld = vld_q;
  assign bus.o_par_err  = par_err_q;
  assign bus.o_frm_err  = frm_err_q;
  assign bus.o_link_ok  = link_q;
  assign bus.o_out      = out_q;

endmodule

// File: tb/tb_sfp_frame_rx.sv
// Directed bench for sfp_frame_rx: latency, link qualification, errors, timeout, LOS, glitches.
module tb_sfp_frame_rx;

  localparam int unsigned OVS      = 4;
  localparam int unsigned TIMEOUT  = 600;
  localparam int unsigned LOCK_CNT = 2;
  localparam int          LAT      = 45;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sfp_frame_rx_if bus ();

  sfp_frame_rx #(.OVS(OVS), .TIMEOUT(TIMEOUT), .LOCK_CNT(LOCK_CNT)) dut (
    .i_clk   (clk),
    .i_res_n (rst_n),
    .bus     (bus)
  );

  always #8 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  int         vld_cyc_q[$];
  logic [7:0] vld_dat_q[$];
  logic       vld_lnk_q[$];
  int         par_cyc_q[$];
  int         frm_cyc_q[$];

  // Pulse logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.o_data_vld === 1'b1) begin
      vld_cyc_q.push_back(cyc);
      vld_dat_q.push_back(bus.o_data);
      vld_lnk_q.push_back(bus.o_link_ok);
    end
    if (bus.o_par_err === 1'b1) par_cyc_q.push_back(cyc);
    if (bus.o_frm_err === 1'b1) frm_cyc_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    vld_cyc_q.delete();
    vld_dat_q.delete();
    vld_lnk_q.delete();
    par_cyc_q.delete();
    frm_cyc_q.delete();
  endtask

  function automatic int lat_of(input int q[$], input int idx, input int e0);
    if (q.size() > idx) return q[idx] - e0;
    return -1;
  endfunction

  // Drives one frame clock by clock; spike >= 0 inverts the line for that one clock.
  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop,
                            input int spike, output int e0);
    logic [10:0] b;
    b  = {stop, (^d) ^ pflip, d, 1'b0};
    e0 = cyc + 1;
    for (int j = 0; j < 11 * int'(OVS); j++) begin
      bus.i_rxd = b[j / int'(OVS)] ^ (j == spike);
      step(1);
    end
  endtask

  int e0a, e0b, vref, c;

  initial begin
    bus.i_rxd          = 1'b1;
    bus.i_sfp_loss_sig = 1'b0;
    step(3);
    chk("rst_data",  32'(bus.o_data),     32'h00);
    chk("rst_out",   32'(bus.o_out),      32'h00);
    chk("rst_link",  32'(bus.o_link_ok),  32'h0);
    chk("rst_vld",   32'(bus.o_data_vld), 32'h0);
    rst_n = 1'b1;
    step(5);
    chk("idle_par",  32'(bus.o_par_err),  32'h0);
    chk("idle_frm",  32'(bus.o_frm_err),  32'h0);
    chk("idle_link", 32'(bus.o_link_ok),  32'h0);

    // Two back-to-back A5 frames qualify the link.
    clear_logs();
    send_frame(8'hA5, 1'b0, 1'b1, -1, e0a);
    send_frame(8'hA5, 1'b0, 1'b1, -1, e0b);
    step(2);
    chk("b2b_link",     32'(bus.o_link_ok), 32'h1);
    chk("b2b_out_lag",  32'(bus.o_out),     32'h00);
    step(1);
    chk("b2b_out",      32'(bus.o_out),     32'hA5);
    chk("b2b_nvld",     32'(vld_cyc_q.size()), 32'd2);
    chk("b2b_lat0",     32'(lat_of(vld_cyc_q, 0, e0a)), 32'(LAT));
    chk("b2b_lat1",     32'(lat_of(vld_cyc_q, 1, e0b)), 32'(LAT));
    chk("b2b_lnk_at0",  32'(vld_lnk_q.size() > 0 ? vld_lnk_q[0] : 1'bx), 32'h0);
    chk("b2b_lnk_at1",  32'(vld_lnk_q.size() > 1 ? vld_lnk_q[1] : 1'bx), 32'h1);
    chk("b2b_data",     32'(bus.o_data),    32'hA5);

    // Parity error while linked.
    clear_logs();
    send_frame(8'h3C, 1'b1, 1'b1, -1, e0a);
    step(4);
    chk("par_n",     32'(par_cyc_q.size()), 32'd1);
    chk("par_lat",   32'(lat_of(par_cyc_q, 0, e0a)), 32'(LAT));
    chk("par_nvld",  32'(vld_cyc_q.size()), 32'd0);
    chk("par_data",  32'(bus.o_data),    32'hA5);
    chk("par_out",   32'(bus.o_out),     32'hA5);
    chk("par_link",  32'(bus.o_link_ok), 32'h1);

    // Framing error with the line held low afterwards.
    clear_logs();
    send_frame(8'h00, 1'b0, 1'b0, -1, e0a);
    step(20);
    chk("frm_n",     32'(frm_cyc_q.size()), 32'd1);
    chk("frm_lat",   32'(lat_of(frm_cyc_q, 0, e0a)), 32'(LAT));
    bus.i_rxd = 1'b1;
    step(10);
    chk("brk_nfrm",  32'(frm_cyc_q.size()), 32'd1);
    chk("brk_nvld",  32'(vld_cyc_q.size()), 32'd0);
    chk("brk_npar",  32'(par_cyc_q.size()), 32'd0);
    send_frame(8'h81, 1'b0, 1'b1, -1, e0a);
    step(4);
    vref = e0a + LAT;
    chk("post_lat",  32'(lat_of(vld_cyc_q, 0, e0a)), 32'(LAT));
    chk("post_data", 32'(bus.o_data),    32'h81);
    chk("post_link", 32'(bus.o_link_ok), 32'h1);
    chk("post_out",  32'(bus.o_out),     32'h81);

    // Timeout after TIMEOUT idle clocks from the last good frame.
    step(vref + int'(TIMEOUT) - 1 - cyc);
    chk("to_before", 32'(bus.o_link_ok), 32'h1);
    step(1);
    chk("to_link",   32'(bus.o_link_ok), 32'h0);
    chk("to_out_lag",32'(bus.o_out),     32'h81);
    step(1);
    chk("to_out",    32'(bus.o_out),     32'h00);

    // One good frame does not relink; the second does.
    clear_logs();
    send_frame(8'hA5, 1'b0, 1'b1, -1, e0a);
    step(4);
    chk("rl1_link",  32'(bus.o_link_ok), 32'h0);
    chk("rl1_data",  32'(bus.o_data),    32'hA5);
    send_frame(8'hC3, 1'b0, 1'b1, -1, e0b);
    step(4);
    chk("rl2_lnk_at",32'(vld_lnk_q.size() > 1 ? vld_lnk_q[1] : 1'bx), 32'h1);
    chk("rl2_out",   32'(bus.o_out),     32'hC3);

    // LOS pulse early in a frame of FE: the line stays high after D0.
    clear_logs();
    bus.i_rxd = 1'b0;
    step(2);
    bus.i_sfp_loss_sig = 1'b1;
    c = cyc;
    step(2);
    chk("los_link_c2", 32'(bus.o_link_ok), 32'h1);
    step(1);
    chk("los_link_c3", 32'(bus.o_link_ok), 32'h0);
    step(1);
    chk("los_out",     32'(bus.o_out),     32'h00);
    step(c + 6 - cyc);
    bus.i_sfp_loss_sig = 1'b0;
    bus.i_rxd          = 1'b1;
    step(60);
    chk("los_nvld",  32'(vld_cyc_q.size()), 32'd0);
    chk("los_npar",  32'(par_cyc_q.size()), 32'd0);
    chk("los_nfrm",  32'(frm_cyc_q.size()), 32'd0);
    chk("los_data",  32'(bus.o_data),       32'hC3);

    // Two-clock low glitch on an idle line.
    clear_logs();
    bus.i_rxd = 1'b0;
    step(2);
    bus.i_rxd = 1'b1;
    step(60);
    chk("gl_nvld",   32'(vld_cyc_q.size()), 32'd0);
    chk("gl_npar",   32'(par_cyc_q.size()), 32'd0);
    chk("gl_nfrm",   32'(frm_cyc_q.size()), 32'd0);

`ifdef SFP_RX_MAJORITY_EN
    send_frame(8'h5A, 1'b0, 1'b1, 10, e0a);
`else
    send_frame(8'h5A, 1'b0, 1'b1, -1, e0a);
`endif
    step(4);
    chk("5a_lat",    32'(lat_of(vld_cyc_q, 0, e0a)), 32'(LAT));
    chk("5a_data",   32'(bus.o_data),       32'h5A);
    chk("5a_npar",   32'(par_cyc_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
